// File: rtl/exe_hazard_ctrl.sv
// Execute-stage hazard and forwarding controller for the ThinPad 5-stage pipeline.
// Define EXE_FWD_EN for operand forwarding; otherwise every RAW hit stalls.
module exe_hazard_ctrl #(
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_rs_re,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_rt_re,
    input  logic             id_st_re,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rd_we,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [1:0]       forward_w,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_STALL  = 2'b01;
    localparam logic [1:0] ST_FLUSH  = 2'b10;
    localparam logic [1:0] ST_FREEZE = 2'b11;

    // Register file writes through in WB, so only EX and MEM producers matter.
    logic             ex_v;
    logic             ex_we;
    logic [REG_W-1:0] ex_rd;
    logic             mem_v;
    logic             mem_we;
    logic [REG_W-1:0] mem_rd;
    logic [1:0]       state_q;

    logic src_a;
    logic src_b;
    logic src_w;
    logic ex_live;
    logic mem_live;
    logic hit_ex_a;
    logic hit_ex_b;
    logic hit_ex_w;
    logic hit_mem_a;
    logic hit_mem_b;
    logic hit_mem_w;
    logic hazard;
    logic kill;

    assign src_a    = id_valid & id_rs_re;
    assign src_b    = id_valid & id_rt_re;
    assign src_w    = id_valid & id_st_re;
    assign ex_live  = ex_v & ex_we;
    assign mem_live = mem_v & mem_we;

    assign hit_ex_a  = src_a & ex_live & (ex_rd == id_rs);
    assign hit_ex_b  = src_b & ex_live & (ex_rd == id_rt);
    assign hit_ex_w  = src_w & ex_live & (ex_rd == id_rt);
    assign hit_mem_a = src_a & mem_live & (mem_rd == id_rs);
    assign hit_mem_b = src_b & mem_live & (mem_rd == id_rt);
    assign hit_mem_w = src_w & mem_live & (mem_rd == id_rt);

`ifdef EXE_FWD_EN
    logic       ex_ld;
    logic [1:0] fa_q;
    logic [1:0] fb_q;
    logic [1:0] fw_q;

    function automatic logic [1:0] fsel(input logic hx, input logic hm);
        if (hx)      return 2'b01;
        else if (hm) return 2'b10;
        else         return 2'b00;
    endfunction

    // Only a load in EX cannot be forwarded in time.
    assign hazard = ex_ld & (hit_ex_a | hit_ex_b | hit_ex_w);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ld <= 1'b0;
            fa_q  <= 2'b00;
            fb_q  <= 2'b00;
            fw_q  <= 2'b00;
        end else if (!mem_busy) begin
            ex_ld <= id_mem_read & ~kill;
            fa_q  <= kill ? 2'b00 : fsel(hit_ex_a, hit_mem_a);
            fb_q  <= kill ? 2'b00 : fsel(hit_ex_b, hit_mem_b);
            fw_q  <= kill ? 2'b00 : fsel(hit_ex_w, hit_mem_w);
        end
    end

    assign forward_a = fa_q;
    assign forward_b = fb_q;
    assign forward_w = fw_q;
`else
    logic unused_ld;

    assign unused_ld = id_mem_read;
    assign hazard = hit_ex_a | hit_ex_b | hit_ex_w
                  | hit_mem_a | hit_mem_b | hit_mem_w;

    assign forward_a = 2'b00;
    assign forward_b = 2'b00;
    assign forward_w = 2'b00;
`endif

    assign kill = ex_redirect | hazard;

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (rst) begin
            pc_stall = 1'b0;
        end else if (mem_busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hazard) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v    <= 1'b0;
            ex_we   <= 1'b0;
            ex_rd   <= '0;
            mem_v   <= 1'b0;
            mem_we  <= 1'b0;
            mem_rd  <= '0;
            state_q <= ST_RUN;
        end else if (mem_busy) begin
            state_q <= ST_FREEZE;
        end else begin
            mem_v   <= ex_v;
            mem_we  <= ex_we;
            mem_rd  <= ex_rd;
            ex_v    <= id_valid & ~kill;
            ex_we   <= id_rd_we;
            ex_rd   <= id_rd;
            if (ex_redirect)  state_q <= ST_FLUSH;
            else if (hazard)  state_q <= ST_STALL;
            else              state_q <= ST_RUN;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Scoreboard bench for exe_hazard_ctrl; expectations follow EXE_FWD_EN.
module tb_exe_hazard_ctrl;

`ifdef EXE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [1:0] RUN = 2'b00, STALL = 2'b01;
    localparam logic [1:0] FLUSH = 2'b10, FREEZE = 2'b11;

    typedef struct packed {
        logic rst, busy, redir, v, rs_re;
        logic [3:0] rs;
        logic rt_re, st_re;
        logic [3:0] rt;
        logic we;
        logic [3:0] rd;
        logic ld;
    } stim_t;

    logic clk = 1'b0;
    logic rst, id_valid, id_rs_re, id_rt_re, id_st_re, id_rd_we;
    logic id_mem_read, ex_redirect, mem_busy;
    logic [3:0] id_rs, id_rt, id_rd;
    logic [1:0] forward_a, forward_b, forward_w, state;
    logic pc_stall, ifid_stall, idex_bubble, ifid_flush;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];

    exe_hazard_ctrl #(.REG_W(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_re(id_rs_re), .id_rs(id_rs),
        .id_rt_re(id_rt_re), .id_st_re(id_st_re), .id_rt(id_rt),
        .id_rd_we(id_rd_we), .id_rd(id_rd),
        .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy),
        .forward_a(forward_a), .forward_b(forward_b),
        .forward_w(forward_w), .pc_stall(pc_stall),
        .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] E(input logic pc, fi, bu, fl,
                                      input logic [1:0] fa, fb, fw, st);
        return {pc, fi, bu, fl, fa, fb, fw, st};
    endfunction

    localparam logic [11:0] Z   = 12'h000;
    localparam logic [11:0] STL = {4'b1110, 6'b0, STALL};

    function automatic stim_t ins(input logic rs_re, input logic [3:0] rs,
                                  input logic rt_re, st_re,
                                  input logic [3:0] rt, input logic we,
                                  input logic [3:0] rd, input logic ld);
        stim_t s;
        s = '0;
        s.v = 1'b1; s.rs_re = rs_re; s.rs = rs; s.rt_re = rt_re;
        s.st_re = st_re; s.rt = rt; s.we = we; s.rd = rd; s.ld = ld;
        return s;
    endfunction

    function automatic stim_t addu(input logic [3:0] rd, rs, rt);
        return ins(1'b1, rs, 1'b1, 1'b0, rt, 1'b1, rd, 1'b0);
    endfunction

    function automatic stim_t lw(input logic [3:0] rd, rs);
        return ins(1'b1, rs, 1'b0, 1'b0, 4'd0, 1'b1, rd, 1'b1);
    endfunction

    function automatic stim_t sw(input logic [3:0] rs, rt);
        return ins(1'b1, rs, 1'b0, 1'b1, rt, 1'b0, 4'd0, 1'b0);
    endfunction

    function automatic stim_t nop();
        return '0;
    endfunction

    function automatic stim_t rst_s();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    // Drive one cycle; comb outputs sampled mid-cycle, registered ones after the edge.
    task automatic cyc(input stim_t s, input logic [11:0] e);
        logic [3:0] c;
        @(negedge clk);
        rst = s.rst; mem_busy = s.busy; ex_redirect = s.redir;
        id_valid = s.v; id_rs_re = s.rs_re; id_rs = s.rs;
        id_rt_re = s.rt_re; id_st_re = s.st_re; id_rt = s.rt;
        id_rd_we = s.we; id_rd = s.rd; id_mem_read = s.ld;
        exp_q.push_back(e);
        #2;
        c = {pc_stall, ifid_stall, idex_bubble, ifid_flush};
        @(posedge clk);
        #1;
        obs_q.push_back({c, forward_a, forward_b, forward_w, state});
    endtask

    task automatic test_reset();
        stim_t s;
        int k = 0;
        s = addu(4'd1, 4'd1, 4'd1);
        s.rst = 1'b1; s.busy = 1'b1; s.redir = 1'b1;
        cyc(s, Z);
        cyc(nop(), Z);
        while (exp_q.size() != 0) begin
            logic [11:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset step%0d got=%b want=%b", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        cyc(rst_s(), Z);
        cyc(addu(4'd1, 4'd2, 4'd3), Z);
        if (FWD) begin
            cyc(addu(4'd2, 4'd1, 4'd3), E(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, RUN));
            cyc(nop(), Z);
        end else begin
            cyc(addu(4'd2, 4'd1, 4'd3), STL);
            cyc(addu(4'd2, 4'd1, 4'd3), STL);
            cyc(addu(4'd2, 4'd1, 4'd3), Z);
        end
        while (exp_q.size() != 0) begin
            logic [11:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL back_to_back step%0d got=%b want=%b", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_load_use();
        int k = 0;
        cyc(rst_s(), Z);
        cyc(lw(4'd4, 4'd2), Z);
        cyc(addu(4'd5, 4'd4, 4'd4), STL);
        if (FWD) begin
            cyc(addu(4'd5, 4'd4, 4'd4), E(0, 0, 0, 0, 2'b10, 2'b10, 2'b00, RUN));
            cyc(nop(), Z);
        end else begin
            cyc(addu(4'd5, 4'd4, 4'd4), STL);
            cyc(addu(4'd5, 4'd4, 4'd4), Z);
        end
        while (exp_q.size() != 0) begin
            logic [11:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL load_use step%0d got=%b want=%b", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_ex_priority();
        int k = 0;
        cyc(rst_s(), Z);
        cyc(addu(4'd1, 4'd2, 4'd3), Z);
        cyc(addu(4'd1, 4'd4, 4'd5), Z);
        if (FWD) begin
            cyc(addu(4'd7, 4'd1, 4'd6), E(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, RUN));
            cyc(nop(), Z);
        end else begin
            cyc(addu(4'd7, 4'd1, 4'd6), STL);
            cyc(addu(4'd7, 4'd1, 4'd6), STL);
            cyc(addu(4'd7, 4'd1, 4'd6), Z);
        end
        while (exp_q.size() != 0) begin
            logic [11:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL ex_priority step%0d got=%b want=%b", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_store();
        int k = 0;
        cyc(rst_s(), Z);
        cyc(addu(4'd6, 4'd1, 4'd2), Z);
        if (FWD) begin
            cyc(sw(4'd0, 4'd6), E(0, 0, 0, 0, 2'b00, 2'b00, 2'b01, RUN));
            cyc(nop(), Z);
        end else begin
            cyc(sw(4'd0, 4'd6), STL);
            cyc(sw(4'd0, 4'd6), STL);
            cyc(sw(4'd0, 4'd6), Z);
        end
        while (exp_q.size() != 0) begin
            logic [11:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL store step%0d got=%b want=%b", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_boundaries();
        stim_t s;
        int k = 0;
        cyc(rst_s(), Z);
        cyc(addu(4'd1, 4'd2, 4'd3), Z);
        s = addu(4'd2, 4'd1, 4'd1);
        s.v = 1'b0;
        cyc(s, Z);
        cyc(addu(4'd0, 4'd2, 4'd3), Z);
        if (FWD) begin
            cyc(addu(4'd4, 4'd0, 4'd0), E(0, 0, 0, 0, 2'b01, 2'b01, 2'b00, RUN));
            cyc(nop(), Z);
        end else begin
            cyc(addu(4'd4, 4'd0, 4'd0), STL);
            cyc(addu(4'd4, 4'd0, 4'd0), STL);
            cyc(addu(4'd4, 4'd0, 4'd0), Z);
        end
        while (exp_q.size() != 0) begin
            logic [11:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL boundaries step%0d got=%b want=%b", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_redirect();
        stim_t s;
        int k = 0;
        cyc(rst_s(), Z);
        cyc(lw(4'd4, 4'd2), Z);
        s = addu(4'd5, 4'd4, 4'd4);
        s.redir = 1'b1;
        cyc(s, E(0, 0, 1, 1, 2'b00, 2'b00, 2'b00, FLUSH));
        cyc(nop(), Z);
        while (exp_q.size() != 0) begin
            logic [11:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL redirect step%0d got=%b want=%b", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_freeze();
        stim_t s;
        logic [11:0] fz;
        int k = 0;
        cyc(rst_s(), Z);
        cyc(addu(4'd2, 4'd1, 4'd1), Z);
        if (FWD) begin
            cyc(lw(4'd4, 4'd2), E(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, RUN));
            fz = E(1, 1, 0, 0, 2'b01, 2'b00, 2'b00, FREEZE);
        end else begin
            cyc(lw(4'd4, 4'd2), STL);
            cyc(lw(4'd4, 4'd2), STL);
            cyc(lw(4'd4, 4'd2), Z);
            fz = E(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, FREEZE);
        end
        for (int i = 0; i < 3; i++) begin
            s = addu(4'd5, 4'd4, 4'd4);
            s.busy = 1'b1;
            s.redir = (i == 1);
            cyc(s, fz);
        end
        cyc(addu(4'd5, 4'd4, 4'd4), STL);
        if (FWD) begin
            cyc(addu(4'd5, 4'd4, 4'd4), E(0, 0, 0, 0, 2'b10, 2'b10, 2'b00, RUN));
        end else begin
            cyc(addu(4'd5, 4'd4, 4'd4), STL);
            cyc(addu(4'd5, 4'd4, 4'd4), Z);
        end
        cyc(nop(), Z);
        while (exp_q.size() != 0) begin
            logic [11:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL freeze step%0d got=%b want=%b", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t s;
        int k = 0;
        cyc(rst_s(), Z);
        cyc(lw(4'd4, 4'd2), Z);
        cyc(addu(4'd5, 4'd4, 4'd4), STL);
        s = addu(4'd5, 4'd4, 4'd4);
        s.rst = 1'b1;
        cyc(s, Z);
        cyc(addu(4'd5, 4'd4, 4'd4), Z);
        while (exp_q.size() != 0) begin
            logic [11:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_mid_stall step%0d got=%b want=%b", k, o, e);
            end
            k++;
        end
    endtask

    initial begin
        rst = 1'b1; mem_busy = 1'b0; ex_redirect = 1'b0;
        id_valid = 1'b0; id_rs_re = 1'b0; id_rs = '0;
        id_rt_re = 1'b0; id_st_re = 1'b0; id_rt = '0;
        id_rd_we = 1'b0; id_rd = '0; id_mem_read = 1'b0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_ex_priority();
        test_store();
        test_boundaries();
        test_redirect();
        test_freeze();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d comparisons", n_cmp);
        $fatal(1);
    end

endmodule
